// File: rtl/inst_fetch.sv
// Instruction fetch unit: keeps a fetch PC, issues one instruction-memory request at a time
// and buffers returned words in a 2-entry in-order FIFO, with redirect/flush handling.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fpc_q, fpc_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic [1:0][31:0]  pc_mem_q, pc_mem_d;
  logic [1:0][31:0]  inst_mem_q, inst_mem_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic push, pop, wr_ptr, outstanding;

  assign outstanding  = (state_q == WAIT_RSP);
  assign wr_ptr       = rd_ptr_q ^ count_q[0];
  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = (count_q != 2'd0);
  assign inst_o       = inst_valid_o ? inst_mem_q[rd_ptr_q] : 32'd0;
  assign inst_pc_o    = inst_valid_o ? pc_mem_q[rd_ptr_q]   : 32'd0;

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    req_pc_d   = req_pc_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = inst_valid_o && inst_ready_i;

    case (state_q)
      IDLE: begin
        if (!redirect_i && (({1'b0, count_q} + {2'b00, outstanding}) < 3'd2)) begin
          req_d   = 1'b1;
          addr_d  = fpc_q;
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (redirect_i) begin
          req_d   = 1'b0;
          addr_d  = 32'd0;
          state_d = imem_gnt_i ? FLUSH : IDLE;
        end else if (imem_gnt_i) begin
          req_d    = 1'b0;
          addr_d   = 32'd0;
          req_pc_d = addr_q;
          fpc_d    = fpc_q + 32'd4;
          state_d  = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (redirect_i) begin
          state_d = imem_rvalid_i ? IDLE : FLUSH;
        end else if (imem_rvalid_i) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (imem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      pc_mem_d[wr_ptr]   = req_pc_q;
      inst_mem_d[wr_ptr] = imem_rdata_i;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // A redirect wins over the sequential PC step and discards everything buffered.
    if (redirect_i) begin
      fpc_d    = {redirect_pc_i[31:2], 2'b00};
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fpc_q      <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= 32'd0;
      req_pc_q   <= 32'd0;
      pc_mem_q   <= '0;
      inst_mem_q <= '0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      req_pc_q   <= req_pc_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule
